xadac_mux: RTL and testbench

XADAC_MUX -- requirements
Module: xadac_mux

---
 rtl/xadac_mux_if.sv | 30 +++
 rtl/xadac_mux.sv | 231 +++++++++++++++++++++++
 tb/tb_xadac_mux.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/xadac_mux_if.sv
// xadac_if: decode and execute request/response channels between a requester
// and an accelerator. The mst side issues requests, the slv side serves them.
interface xadac_if;
  logic        dec_req_valid;
  logic        dec_req_ready;
  logic [31:0] dec_req;
  logic        dec_rsp_valid;
  logic        dec_rsp_ready;
  logic [31:0] dec_rsp;
  logic        exe_req_valid;
  logic        exe_req_ready;
  logic [31:0] exe_req;
  logic        exe_rsp_valid;
  logic        exe_rsp_ready;
  logic [31:0] exe_rsp;

  modport mst (
    output dec_req_valid, dec_req, dec_rsp_ready,
    output exe_req_valid, exe_req, exe_rsp_ready,
    input  dec_req_ready, dec_rsp_valid, dec_rsp,
    input  exe_req_ready, exe_rsp_valid, exe_rsp
  );

  modport slv (
    input  dec_req_valid, dec_req, dec_rsp_ready,
    input  exe_req_valid, exe_req, exe_rsp_ready,
    output dec_req_ready, dec_rsp_valid, dec_rsp,
    output exe_req_ready, exe_rsp_valid, exe_rsp
  );
endinterface

// File: rtl/xadac_mux.sv
// xadac_mux: shares one accelerator among NumMst requesters. Decode and
// execute channels each get a round-robin arbiter with stall lock and an
// in-order route FIFO that steers responses back to the issuing requester.

module xadac_mux_chk (
  input logic clk_i,
  input logic rst_ni,
  input logic rsp_valid,
  input logic fifo_empty
);
  // A response with no outstanding request means the accelerator broke protocol.
  a_rsp_while_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rsp_valid && fifo_empty));
endmodule

module xadac_mux_chan #(
  parameter int N     = 2,
  parameter int Depth = 4,
  parameter int DataW = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             m_req_valid [N],
  input  logic [DataW-1:0] m_req       [N],
  output logic             m_req_ready [N],
  output logic [DataW-1:0] s_req,
  output logic             s_req_valid,
  input  logic             s_req_ready,
  input  logic             m_rsp_ready [N],
  output logic             m_rsp_valid [N],
  output logic [DataW-1:0] m_rsp,
  input  logic [DataW-1:0] s_rsp,
  input  logic             s_rsp_valid,
  output logic             s_rsp_ready
);
  localparam int IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [IdxW-1:0] ptr_r;
  logic            lock_r;
  logic [IdxW-1:0] lock_idx_r;
  logic [IdxW-1:0] route_q_r [Depth];
  logic [PtrW-1:0] wr_r;
  logic [PtrW-1:0] rd_r;
  logic [CntW-1:0] cnt_r;

  logic [IdxW-1:0] pick_s;
  logic            pick_vld_s;
  logic [IdxW:0]   cand_s;
  logic            hit_s;
  logic [IdxW-1:0] gnt_s;
  logic            gnt_vld_s;
  logic            full_s;
  logic            empty_s;
  logic            push_s;
  logic            pop_s;
  logic [IdxW-1:0] head_s;

  // Advance a route FIFO pointer, wrapping at Depth (need not be a power of two).
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? {PtrW{1'b0}} : p + PtrW'(1'b1);
  endfunction

  // Round-robin pick: first requesting master at or after the priority pointer.
  always_comb begin
    pick_s     = ptr_r;
    pick_vld_s = 1'b0;
    cand_s     = {(IdxW + 1){1'b0}};
    hit_s      = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand_s     = {1'b0, ptr_r} + (IdxW + 1)'(k);
      cand_s     = (cand_s >= (IdxW + 1)'(N)) ? cand_s - (IdxW + 1)'(N) : cand_s;
      hit_s      = !pick_vld_s && m_req_valid[cand_s[IdxW-1:0]];
      pick_s     = hit_s ? cand_s[IdxW-1:0] : pick_s;
      pick_vld_s = pick_vld_s | hit_s;
    end
  end

  // A stalled request keeps its grant so payload/valid stay stable downstream.
  assign gnt_s     = lock_r ? lock_idx_r : pick_s;
  assign gnt_vld_s = lock_r | pick_vld_s;
  // Fullness comes only from registered occupancy, so requests never wait on responses.
  assign full_s    = (cnt_r == CntW'(Depth));
  assign empty_s   = (cnt_r == {CntW{1'b0}});
  assign head_s    = route_q_r[rd_r];

  assign s_req_valid = rst_ni & gnt_vld_s & ~full_s;
  assign s_req       = m_req[gnt_s];
  assign push_s      = s_req_valid & s_req_ready;

  assign s_rsp_ready = rst_ni & ~empty_s & m_rsp_ready[head_s];
  assign m_rsp       = s_rsp;
  assign pop_s       = s_rsp_valid & s_rsp_ready;

  // Per-master ready and response-valid: only the granted / head master sees them.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      m_req_ready[i] = rst_ni & gnt_vld_s & ~full_s & s_req_ready & (gnt_s == IdxW'(i));
      m_rsp_valid[i] = rst_ni & ~empty_s & s_rsp_valid & (head_s == IdxW'(i));
    end
  end

  // Arbitration pointer and stall lock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_r      <= {IdxW{1'b0}};
      lock_r     <= 1'b0;
      lock_idx_r <= {IdxW{1'b0}};
    end else begin
      lock_r     <= s_req_valid & ~s_req_ready;
      lock_idx_r <= gnt_s;
      if (push_s) begin
        ptr_r <= (gnt_s == IdxW'(N - 1)) ? {IdxW{1'b0}} : gnt_s + IdxW'(1'b1);
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

  // Route FIFO: granted index in on request handshake, head out on response handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int d = 0; d < Depth; d++) begin
        route_q_r[d] <= {IdxW{1'b0}};
      end
      wr_r  <= {PtrW{1'b0}};
      rd_r  <= {PtrW{1'b0}};
      cnt_r <= {CntW{1'b0}};
    end else begin
      if (push_s) begin
        route_q_r[wr_r] <= gnt_s;
        wr_r            <= ptr_inc(wr_r);
      end else begin
        wr_r <= wr_r;
      end
      if (pop_s) begin
        rd_r <= ptr_inc(rd_r);
      end else begin
        rd_r <= rd_r;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CntW'(1'b1);
        2'b01:   cnt_r <= cnt_r - CntW'(1'b1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  xadac_mux_chk u_chk (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rsp_valid  (s_rsp_valid),
    .fifo_empty (empty_s)
  );
endmodule

module xadac_mux #(
  parameter int NumMst   = 2,
  parameter int DecDepth = 4,
  parameter int ExeDepth = 4
) (
  input logic   clk_i,
  input logic   rst_ni,
  xadac_if.slv  mst [NumMst],
  xadac_if.mst  slv
);
  localparam int DataW = 32;

  logic             dec_req_valid_s [NumMst];
  logic [DataW-1:0] dec_req_s       [NumMst];
  logic             dec_req_ready_s [NumMst];
  logic             dec_rsp_ready_s [NumMst];
  logic             dec_rsp_valid_s [NumMst];
  logic [DataW-1:0] dec_rsp_s;
  logic             exe_req_valid_s [NumMst];
  logic [DataW-1:0] exe_req_s       [NumMst];
  logic             exe_req_ready_s [NumMst];
  logic             exe_rsp_ready_s [NumMst];
  logic             exe_rsp_valid_s [NumMst];
  logic [DataW-1:0] exe_rsp_s;

  for (genvar i = 0; i < NumMst; i++) begin : g_map
    assign dec_req_valid_s[i]  = mst[i].dec_req_valid;
    assign dec_req_s[i]        = mst[i].dec_req;
    assign dec_rsp_ready_s[i]  = mst[i].dec_rsp_ready;
    assign mst[i].dec_req_ready = dec_req_ready_s[i];
    assign mst[i].dec_rsp_valid = dec_rsp_valid_s[i];
    assign mst[i].dec_rsp       = dec_rsp_s;
    assign exe_req_valid_s[i]  = mst[i].exe_req_valid;
    assign exe_req_s[i]        = mst[i].exe_req;
    assign exe_rsp_ready_s[i]  = mst[i].exe_rsp_ready;
    assign mst[i].exe_req_ready = exe_req_ready_s[i];
    assign mst[i].exe_rsp_valid = exe_rsp_valid_s[i];
    assign mst[i].exe_rsp       = exe_rsp_s;
  end

  xadac_mux_chan #(.N(NumMst), .Depth(DecDepth), .DataW(DataW)) u_dec (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .m_req_valid (dec_req_valid_s),
    .m_req       (dec_req_s),
    .m_req_ready (dec_req_ready_s),
    .s_req       (slv.dec_req),
    .s_req_valid (slv.dec_req_valid),
    .s_req_ready (slv.dec_req_ready),
    .m_rsp_ready (dec_rsp_ready_s),
    .m_rsp_valid (dec_rsp_valid_s),
    .m_rsp       (dec_rsp_s),
    .s_rsp       (slv.dec_rsp),
    .s_rsp_valid (slv.dec_rsp_valid),
    .s_rsp_ready (slv.dec_rsp_ready)
  );

  xadac_mux_chan #(.N(NumMst), .Depth(ExeDepth), .DataW(DataW)) u_exe (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .m_req_valid (exe_req_valid_s),
    .m_req       (exe_req_s),
    .m_req_ready (exe_req_ready_s),
    .s_req       (slv.exe_req),
    .s_req_valid (slv.exe_req_valid),
    .s_req_ready (slv.exe_req_ready),
    .m_rsp_ready (exe_rsp_ready_s),
    .m_rsp_valid (exe_rsp_valid_s),
    .m_rsp       (exe_rsp_s),
    .s_rsp       (slv.exe_rsp),
    .s_rsp_valid (slv.exe_rsp_valid),
    .s_rsp_ready (slv.exe_rsp_ready)
  );
endmodule

// File: tb/tb_xadac_mux.sv
// Directed bench for xadac_mux with three requesters and depth-4 route FIFOs.
module tb_xadac_mux;
  logic clk = 1'b0;
  logic rst_ni;
  int   checks;
  int   errors;

  xadac_if mst_if [3] ();
  xadac_if slv_if ();

  logic [2:0]  m_dec_valid, m_exe_valid, m_dec_rsp_ready, m_exe_rsp_ready;
  logic [31:0] m_dec_req [3];
  logic [31:0] m_exe_req [3];
  wire  [2:0]  m_dec_ready, m_exe_ready, m_dec_rsp_valid, m_exe_rsp_valid;
  int          route_seq [3] = '{1, 0, 1};

  for (genvar i = 0; i < 3; i++) begin : g_tb
    assign mst_if[i].dec_req_valid = m_dec_valid[i];
    assign mst_if[i].dec_req       = m_dec_req[i];
    assign mst_if[i].dec_rsp_ready = m_dec_rsp_ready[i];
    assign mst_if[i].exe_req_valid = m_exe_valid[i];
    assign mst_if[i].exe_req       = m_exe_req[i];
    assign mst_if[i].exe_rsp_ready = m_exe_rsp_ready[i];
    assign m_dec_ready[i]     = mst_if[i].dec_req_ready;
    assign m_dec_rsp_valid[i] = mst_if[i].dec_rsp_valid;
    assign m_exe_ready[i]     = mst_if[i].exe_req_ready;
    assign m_exe_rsp_valid[i] = mst_if[i].exe_rsp_valid;
  end

  xadac_mux #(.NumMst(3), .DecDepth(4), .ExeDepth(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .mst    (mst_if),
    .slv    (slv_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_ni = 1'b0;
    m_dec_valid = 3'b000; m_exe_valid = 3'b000;
    m_dec_rsp_ready = 3'b111; m_exe_rsp_ready = 3'b111;
    for (int i = 0; i < 3; i++) begin
      m_dec_req[i] = 32'hD000_0000 | 32'(i);
      m_exe_req[i] = 32'hE000_0000 | 32'(i);
    end
    slv_if.dec_req_ready = 1'b0; slv_if.exe_req_ready = 1'b0;
    slv_if.dec_rsp_valid = 1'b0; slv_if.exe_rsp_valid = 1'b0;
    slv_if.dec_rsp = 32'h0; slv_if.exe_rsp = 32'h0;

    // Reset holds every valid/ready low even with active inputs.
    #2;
    m_dec_valid = 3'b111; m_exe_valid = 3'b111;
    slv_if.dec_req_ready = 1'b1; slv_if.exe_req_ready = 1'b1;
    #1;
    chk("rst_dec_req_valid", 32'(slv_if.dec_req_valid), 32'h0);
    chk("rst_exe_req_valid", 32'(slv_if.exe_req_valid), 32'h0);
    chk("rst_dec_req_ready", 32'(m_dec_ready), 32'h0);
    chk("rst_exe_req_ready", 32'(m_exe_ready), 32'h0);
    chk("rst_dec_rsp_ready", 32'(slv_if.dec_rsp_ready), 32'h0);
    m_dec_valid = 3'b000; m_exe_valid = 3'b000;
    slv_if.exe_req_ready = 1'b0;
    repeat (2) cyc();
    rst_ni = 1'b1;

    // Round-robin fairness with responses draining one behind.
    m_dec_valid = 3'b111;
    slv_if.dec_rsp = 32'h0000_ABCD;
    for (int k = 0; k < 6; k++) begin
      slv_if.dec_rsp_valid = (k > 0);
      mid();
      chk("rr_grant", slv_if.dec_req, m_dec_req[k % 3]);
      chk("rr_ready", 32'(m_dec_ready), 32'(3'b001 << (k % 3)));
      if (k > 0) chk("rr_rsp_route", 32'(m_dec_rsp_valid), 32'(3'b001 << ((k - 1) % 3)));
      cyc();
    end
    m_dec_valid = 3'b000;
    mid();
    chk("rr_rsp_last", 32'(m_dec_rsp_valid), 32'h4);
    chk("rr_rsp_data", mst_if[2].dec_rsp, 32'h0000_ABCD);
    chk("rr_idle_valid", 32'(slv_if.dec_req_valid), 32'h0);
    cyc();
    slv_if.dec_rsp_valid = 1'b0;
    mid();
    chk("rr_occ_drained", 32'(dut.u_dec.cnt_r), 32'h0);
    cyc();

    // Response routing: requests 1,0,1 come back to 1,0,1.
    for (int k = 0; k < 3; k++) begin
      m_dec_valid = 3'(3'b001 << route_seq[k]);
      mid();
      chk("route_req", slv_if.dec_req, m_dec_req[route_seq[k]]);
      cyc();
    end
    m_dec_valid = 3'b000;
    mid();
    chk("route_occ3", 32'(dut.u_dec.cnt_r), 32'h3);
    cyc();
    m_dec_rsp_ready = 3'b101;
    slv_if.dec_rsp_valid = 1'b1;
    mid();
    chk("route_hold_ready", 32'(slv_if.dec_rsp_ready), 32'h0);
    chk("route_hold_valid", 32'(m_dec_rsp_valid), 32'h2);
    cyc();
    m_dec_rsp_ready = 3'b111;
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("route_rsp", 32'(m_dec_rsp_valid), 32'(3'b001 << route_seq[k]));
      chk("route_rsp_ready", 32'(slv_if.dec_rsp_ready), 32'h1);
      cyc();
    end
    slv_if.dec_rsp_valid = 1'b0;
    mid();
    chk("route_occ0", 32'(dut.u_dec.cnt_r), 32'h0);
    chk("route_idle", 32'(m_dec_rsp_valid), 32'h0);
    cyc();

    // Exe stall lock: mst1 held through 3 stalled cycles while mst0 requests.
    m_exe_valid = 3'b010;
    mid();
    chk("stall_first", slv_if.exe_req, m_exe_req[1]);
    chk("stall_first_valid", 32'(slv_if.exe_req_valid), 32'h1);
    cyc();
    m_exe_valid = 3'b011;
    for (int k = 0; k < 2; k++) begin
      mid();
      chk("stall_payload", slv_if.exe_req, m_exe_req[1]);
      chk("stall_valid", 32'(slv_if.exe_req_valid), 32'h1);
      chk("stall_ready", 32'(m_exe_ready), 32'h0);
      cyc();
    end
    slv_if.exe_req_ready = 1'b1;
    mid();
    chk("stall_hs_payload", slv_if.exe_req, m_exe_req[1]);
    chk("stall_hs_ready", 32'(m_exe_ready), 32'h2);
    cyc();
    mid();
    chk("stall_next_grant", slv_if.exe_req, m_exe_req[0]);
    chk("stall_next_ready", 32'(m_exe_ready), 32'h1);
    cyc();
    m_exe_valid = 3'b000;
    slv_if.exe_req_ready = 1'b0;
    slv_if.exe_rsp = 32'h1234_5678;
    slv_if.exe_rsp_valid = 1'b1;
    mid();
    chk("exe_rsp_route1", 32'(m_exe_rsp_valid), 32'h2);
    chk("exe_rsp_data", mst_if[1].exe_rsp, 32'h1234_5678);
    cyc();
    mid();
    chk("exe_rsp_route0", 32'(m_exe_rsp_valid), 32'h1);
    cyc();
    slv_if.exe_rsp_valid = 1'b0;
    mid();
    chk("exe_occ0", 32'(dut.u_exe.cnt_r), 32'h0);
    cyc();

    // Fill, concurrent push/pop at occupancy 2, full backpressure, pop at full.
    m_dec_valid = 3'b111;
    mid(); chk("fill_g2", slv_if.dec_req, m_dec_req[2]); cyc();
    mid(); chk("fill_g0", slv_if.dec_req, m_dec_req[0]); cyc();
    slv_if.dec_rsp_valid = 1'b1;
    mid();
    chk("conc_occ_before", 32'(dut.u_dec.cnt_r), 32'h2);
    chk("conc_grant", slv_if.dec_req, m_dec_req[1]);
    chk("conc_rsp_route", 32'(m_dec_rsp_valid), 32'h4);
    cyc();
    slv_if.dec_rsp_valid = 1'b0;
    mid();
    chk("conc_occ_after", 32'(dut.u_dec.cnt_r), 32'h2);
    chk("fill_g2b", slv_if.dec_req, m_dec_req[2]);
    cyc();
    mid(); chk("fill_g0b", slv_if.dec_req, m_dec_req[0]); cyc();
    slv_if.dec_rsp_valid = 1'b1;
    mid();
    chk("full_occ", 32'(dut.u_dec.cnt_r), 32'h4);
    chk("full_req_valid", 32'(slv_if.dec_req_valid), 32'h0);
    chk("full_req_ready", 32'(m_dec_ready), 32'h0);
    chk("full_rsp_route", 32'(m_dec_rsp_valid), 32'h1);
    cyc();
    slv_if.dec_rsp_valid = 1'b0;
    mid();
    chk("full_pop_occ", 32'(dut.u_dec.cnt_r), 32'h3);
    chk("resume_valid", 32'(slv_if.dec_req_valid), 32'h1);
    chk("resume_grant", slv_if.dec_req, m_dec_req[1]);
    chk("resume_ready", 32'(m_dec_ready), 32'h2);
    cyc();
    m_dec_valid = 3'b000;
    slv_if.dec_rsp_valid = 1'b1;
    mid();
    chk("drain_route", 32'(m_dec_rsp_valid), 32'h2);
    cyc();

    // Reset with 3 outstanding: outputs drop at once, state clears.
    m_dec_valid = 3'b111; m_exe_valid = 3'b111;
    slv_if.exe_req_ready = 1'b1;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_dec_valid", 32'(slv_if.dec_req_valid), 32'h0);
    chk("mid_rst_dec_ready", 32'(m_dec_ready), 32'h0);
    chk("mid_rst_exe_valid", 32'(slv_if.exe_req_valid), 32'h0);
    chk("mid_rst_rsp_ready", 32'(slv_if.dec_rsp_ready), 32'h0);
    chk("mid_rst_rsp_valid", 32'(m_dec_rsp_valid), 32'h0);
    slv_if.dec_rsp_valid = 1'b0;
    m_exe_valid = 3'b000;
    slv_if.exe_req_ready = 1'b0;
    repeat (2) cyc();
    rst_ni = 1'b1;
    mid();
    chk("post_rst_occ", 32'(dut.u_dec.cnt_r), 32'h0);
    chk("post_rst_grant", slv_if.dec_req, m_dec_req[0]);
    chk("post_rst_ready", 32'(m_dec_ready), 32'h1);
    chk("post_rst_rsp_valid", 32'(m_dec_rsp_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
